cb_sram_ctrl: RTL and testbench

CB_SRAM_CTRL -- requirements
Module: cb_sram_ctrl

---
 rtl/cb_sram_ctrl.sv | 278 +++++++++++++++++++++++++++
 tb/tb_cb_sram_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// cb_sram_ctrl
//
// Bridges the LSU core-bus (split write-address / write-data / write-response
// and read-address / read-data channels) onto a single-port synchronous SRAM
// with a 1-cycle read latency.
//
// Package cb_pkg (in this file) carries the core-bus types shared with the
// rest of the core.
//
// Parameters
//   MEM_BASE     byte base address of the SRAM window
//   MEM_KB       SRAM size in KiB; AW word-address bits follow from it
//
// Ports
//   clk          sole clock
//   rst          asynchronous active-low reset
//   cb_mosi_i    core-bus requests from the LSU
//   cb_miso_o    core-bus responses to the LSU
//   sram_en_o    SRAM access enable
//   sram_we_o    SRAM byte write enables (0 = read)
//   sram_addr_o  SRAM word address
//   sram_wdata_o SRAM write data
//   sram_rdata_i SRAM read data, valid one cycle after a read enable
// -----------------------------------------------------------------------------

package cb_pkg;

    localparam logic [1:0] CB_OKAY   = 2'b00;
    localparam logic [1:0] CB_EXOKAY = 2'b01;
    localparam logic [1:0] CB_SLVERR = 2'b10;
    localparam logic [1:0] CB_DECERR = 2'b11;

    typedef struct packed {
        logic        wr_addr_valid;
        logic [31:0] wr_addr;
        logic [2:0]  wr_size;
        logic        wr_data_valid;
        logic [31:0] wr_data;
        logic [3:0]  wr_strobe;
        logic        wr_resp_ready;
        logic        rd_addr_valid;
        logic [31:0] rd_addr;
        logic [2:0]  rd_size;
        logic        rd_ready;
    } s_cb_mosi_t;

    typedef struct packed {
        logic        wr_addr_ready;
        logic        wr_data_ready;
        logic        wr_resp_valid;
        logic [1:0]  wr_resp_error;
        logic        rd_addr_ready;
        logic        rd_valid;
        logic [31:0] rd_data;
        logic [1:0]  rd_resp;
    } s_cb_miso_t;

endpackage

module cb_sram_ctrl
    import cb_pkg::*;
#(
    parameter logic [31:0] MEM_BASE = 32'h8000_0000,
    parameter int          MEM_KB   = 8,
    localparam int         AW       = $clog2(MEM_KB * 256)
) (
    input  logic           clk,
    input  logic           rst,
    input  s_cb_mosi_t     cb_mosi_i,
    output s_cb_miso_t     cb_miso_o,
    output logic           sram_en_o,
    output logic [3:0]     sram_we_o,
    output logic [AW-1:0]  sram_addr_o,
    output logic [31:0]    sram_wdata_o,
    input  logic [31:0]    sram_rdata_i
);

    // Window size in bytes, one bit wider than the address so the compare
    // cannot overflow even for a window ending at 4 GiB.
    localparam logic [32:0] MEM_BYTES = 33'(longint'(MEM_KB) * 64'd1024);

    // Read data channel: LIVE presents SRAM data straight from the macro,
    // HOLD presents the captured copy after the consumer stalled.
    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_LIVE = 2'd1,
        RD_HOLD = 2'd2
    } rd_state_t;

    // -------------------------------------------------------------------------
    // Address decode for both channels: index 0 = write, 1 = read
    // -------------------------------------------------------------------------
    logic [31:0]   dec_addr [2];
    logic [1:0]    dec_hit;
    logic [AW-1:0] dec_word [2];
    logic [1:0]    dec_unused;

    assign dec_addr[0] = cb_mosi_i.wr_addr;
    assign dec_addr[1] = cb_mosi_i.rd_addr;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dec
            logic [31:0] offset;
            assign offset          = dec_addr[gi] - MEM_BASE;
            assign dec_hit[gi]     = (dec_addr[gi] >= MEM_BASE) && ({1'b0, offset} < MEM_BYTES);
            assign dec_word[gi]    = offset[AW+1:2];
            // Byte offset and out-of-window bits never select anything.
            assign dec_unused[gi]  = ^{offset[31:AW+2], offset[1:0]};
        end
    endgenerate

    // Transfer size is irrelevant: every access is a full word with strobes.
    logic size_unused;
    assign size_unused = ^{cb_mosi_i.wr_size, cb_mosi_i.rd_size, dec_unused};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic          wa_vld_reg,        wa_vld_next;
    logic [AW-1:0] wa_addr_reg,       wa_addr_next;
    logic          wa_hit_reg,        wa_hit_next;
    logic          wr_resp_valid_reg, wr_resp_valid_next;
    logic [1:0]    wr_resp_err_reg,   wr_resp_err_next;
    rd_state_t     rd_state_reg,      rd_state_next;
    logic          rd_hit_reg,        rd_hit_next;
    logic [31:0]   hold_reg,          hold_next;

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    logic        wr_data_ready;
    logic        wr_addr_ready;
    logic        wdata_fire;
    logic        waddr_fire;
    logic        rd_valid;
    logic        rd_done;
    logic        rd_addr_ready;
    logic        raddr_fire;
    logic [31:0] rd_data_cur;

    // A data beat may complete only while the response slot is free or is
    // being drained this very cycle.
    assign wr_data_ready = wa_vld_reg & ~(wr_resp_valid_reg & ~cb_mosi_i.wr_resp_ready);
    assign wdata_fire    = cb_mosi_i.wr_data_valid & wr_data_ready;
    // The slot refills in the cycle it empties, so writes stream one per clock.
    assign wr_addr_ready = ~wa_vld_reg | wdata_fire;
    assign waddr_fire    = cb_mosi_i.wr_addr_valid & wr_addr_ready;

    assign rd_valid      = (rd_state_reg != RD_IDLE);
    assign rd_done       = rd_valid & cb_mosi_i.rd_ready;
    // A write beat owns the SRAM port this cycle; the read waits.
    assign rd_addr_ready = ~wdata_fire & (~rd_valid | rd_done);
    assign raddr_fire    = cb_mosi_i.rd_addr_valid & rd_addr_ready;

    always_comb begin
        rd_data_cur = 32'd0;
        case (rd_state_reg)
            RD_LIVE: rd_data_cur = rd_hit_reg ? sram_rdata_i : 32'd0;
            RD_HOLD: rd_data_cur = hold_reg;
            default: rd_data_cur = 32'd0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        wa_vld_next        = wa_vld_reg;
        wa_addr_next       = wa_addr_reg;
        wa_hit_next        = wa_hit_reg;
        wr_resp_valid_next = wr_resp_valid_reg;
        wr_resp_err_next   = wr_resp_err_reg;

        if (waddr_fire) begin
            wa_vld_next  = 1'b1;
            wa_addr_next = dec_word[0];
            wa_hit_next  = dec_hit[0];
        end else if (wdata_fire) begin
            wa_vld_next  = 1'b0;
        end

        if (wdata_fire) begin
            wr_resp_valid_next = 1'b1;
            wr_resp_err_next   = wa_hit_reg ? CB_OKAY : CB_SLVERR;
        end else if (cb_mosi_i.wr_resp_ready) begin
            wr_resp_valid_next = 1'b0;
        end
    end

    always_comb begin
        rd_state_next = rd_state_reg;
        rd_hit_next   = rd_hit_reg;
        hold_next     = hold_reg;

        case (rd_state_reg)
            RD_IDLE: rd_state_next = RD_IDLE;
            RD_LIVE: rd_state_next = cb_mosi_i.rd_ready ? RD_IDLE : RD_HOLD;
            RD_HOLD: rd_state_next = cb_mosi_i.rd_ready ? RD_IDLE : RD_HOLD;
            default: rd_state_next = RD_IDLE;
        endcase

        // SRAM data is only valid for one cycle, so a stalled beat must be
        // captured on its first cycle.
        if (rd_state_reg == RD_LIVE && !cb_mosi_i.rd_ready) begin
            hold_next = rd_data_cur;
        end

        if (raddr_fire) begin
            rd_state_next = RD_LIVE;
            rd_hit_next   = dec_hit[1];
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wa_vld_reg        <= 1'b0;
            wa_addr_reg       <= '0;
            wa_hit_reg        <= 1'b0;
            wr_resp_valid_reg <= 1'b0;
            wr_resp_err_reg   <= CB_OKAY;
            rd_state_reg      <= RD_IDLE;
            rd_hit_reg        <= 1'b0;
            hold_reg          <= 32'd0;
        end else begin
            wa_vld_reg        <= wa_vld_next;
            wa_addr_reg       <= wa_addr_next;
            wa_hit_reg        <= wa_hit_next;
            wr_resp_valid_reg <= wr_resp_valid_next;
            wr_resp_err_reg   <= wr_resp_err_next;
            rd_state_reg      <= rd_state_next;
            rd_hit_reg        <= rd_hit_next;
            hold_reg          <= hold_next;
        end
    end

    // -------------------------------------------------------------------------
    // SRAM port. Gated by rst so a read request presented during reset
    // cannot reach the macro while the ready outputs sit at their reset values.
    // -------------------------------------------------------------------------
    always_comb begin
        sram_en_o    = 1'b0;
        sram_we_o    = 4'b0000;
        sram_addr_o  = '0;
        sram_wdata_o = 32'd0;
        if (rst) begin
            if (wdata_fire && wa_hit_reg) begin
                sram_en_o    = 1'b1;
                sram_we_o    = cb_mosi_i.wr_strobe;
                sram_addr_o  = wa_addr_reg;
                sram_wdata_o = cb_mosi_i.wr_data;
            end else if (raddr_fire && dec_hit[1]) begin
                sram_en_o    = 1'b1;
                sram_addr_o  = dec_word[1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Core-bus responses
    // -------------------------------------------------------------------------
    always_comb begin
        cb_miso_o               = '0;
        cb_miso_o.wr_addr_ready = wr_addr_ready;
        cb_miso_o.wr_data_ready = wr_data_ready;
        cb_miso_o.wr_resp_valid = wr_resp_valid_reg;
        cb_miso_o.wr_resp_error = wr_resp_valid_reg ? wr_resp_err_reg : CB_OKAY;
        cb_miso_o.rd_addr_ready = rd_addr_ready;
        cb_miso_o.rd_valid      = rd_valid;
        cb_miso_o.rd_data       = rd_data_cur;
        cb_miso_o.rd_resp       = (rd_valid && !rd_hit_reg) ? CB_SLVERR : CB_OKAY;
    end

endmodule

// File: tb/tb_cb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cb_sram_ctrl
//
// Directed bench for cb_sram_ctrl: a vector table of single write/read
// transactions plus hand-written sequences for back-pressure, streaming,
// write/read collision and reset in the middle of a transaction.
// -----------------------------------------------------------------------------
module tb_cb_sram_ctrl;
    import cb_pkg::*;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          AW   = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    s_cb_mosi_t    mosi;
    s_cb_miso_t    miso;
    logic          sram_en;
    logic [3:0]    sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    always #5 clk = ~clk;

    cb_sram_ctrl #(
        .MEM_BASE (BASE),
        .MEM_KB   (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cb_mosi_i    (mosi),
        .cb_miso_o    (miso),
        .sram_en_o    (sram_en),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_rdata_i (sram_rdata)
    );

    // SRAM model: byte-masked writes, 1-cycle read latency, and garbage on
    // the read bus whenever no read was issued the previous cycle.
    logic [31:0] mem [2048];
    always @(posedge clk) begin
        sram_rdata <= $urandom;
        if (sram_en) begin
            if (sram_we == 4'b0000) begin
                sram_rdata <= mem[sram_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_we[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
                end
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] strb,
                            input logic [31:0] data, input logic [1:0] exp_resp,
                            input logic [AW-1:0] exp_word);
        logic hit;
        hit = (exp_resp == CB_OKAY);
        mosi.wr_addr_valid = 1'b1;
        mosi.wr_addr       = addr;
        #1;
        chk("wr_addr_ready", 32'(miso.wr_addr_ready), 32'd1);
        step();
        mosi.wr_addr_valid = 1'b0;
        mosi.wr_data_valid = 1'b1;
        mosi.wr_data       = data;
        mosi.wr_strobe     = strb;
        #1;
        chk("wr_data_ready", 32'(miso.wr_data_ready), 32'd1);
        chk("wr_sram_en", 32'(sram_en), 32'(hit));
        if (hit) begin
            chk("wr_sram_we", 32'(sram_we), 32'(strb));
            chk("wr_sram_addr", 32'(sram_addr), 32'(exp_word));
            chk("wr_sram_wdata", sram_wdata, data);
        end
        step();
        mosi.wr_data_valid = 1'b0;
        chk("wr_resp_valid", 32'(miso.wr_resp_valid), 32'd1);
        chk("wr_resp_error", 32'(miso.wr_resp_error), 32'(exp_resp));
        mosi.wr_resp_ready = 1'b1;
        step();
        mosi.wr_resp_ready = 1'b0;
        chk("wr_resp_cleared", 32'(miso.wr_resp_valid), 32'd0);
        $display("write addr=%h strb=%b data=%h resp=%0d", addr, strb, data, exp_resp);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [1:0] exp_resp,
                           input logic [31:0] exp_data, input logic [AW-1:0] exp_word);
        logic hit;
        hit = (exp_resp == CB_OKAY);
        mosi.rd_addr_valid = 1'b1;
        mosi.rd_addr       = addr;
        mosi.rd_ready      = 1'b1;
        #1;
        chk("rd_addr_ready", 32'(miso.rd_addr_ready), 32'd1);
        chk("rd_sram_en", 32'(sram_en), 32'(hit));
        if (hit) begin
            chk("rd_sram_we", 32'(sram_we), 32'd0);
            chk("rd_sram_addr", 32'(sram_addr), 32'(exp_word));
        end
        step();
        mosi.rd_addr_valid = 1'b0;
        #1;
        chk("rd_valid", 32'(miso.rd_valid), 32'd1);
        chk("rd_data", miso.rd_data, exp_data);
        chk("rd_resp", 32'(miso.rd_resp), 32'(exp_resp));
        step();
        chk("rd_valid_cleared", 32'(miso.rd_valid), 32'd0);
        mosi.rd_ready = 1'b0;
        $display("read  addr=%h data=%h resp=%0d", addr, miso.rd_data, exp_resp);
    endtask

    typedef struct {
        logic          is_wr;
        logic [31:0]   addr;
        logic [3:0]    strb;
        logic [31:0]   data;      // write data or expected read data
        logic [1:0]    resp;
        logic [AW-1:0] word;
    } vec_t;

    vec_t vecs [17];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] b2b_addr [3];
        logic [31:0] b2b_data [3];

        vecs[0]  = '{1'b1, 32'h8000_0010, 4'b1111, 32'hDEAD_BEEF, CB_OKAY,   11'd4};
        vecs[1]  = '{1'b0, 32'h8000_0010, 4'b0000, 32'hDEAD_BEEF, CB_OKAY,   11'd4};
        vecs[2]  = '{1'b1, 32'h8000_0020, 4'b1111, 32'h1122_3344, CB_OKAY,   11'd8};
        vecs[3]  = '{1'b1, 32'h8000_0020, 4'b0100, 32'h00AA_0000, CB_OKAY,   11'd8};
        vecs[4]  = '{1'b0, 32'h8000_0020, 4'b0000, 32'h11AA_3344, CB_OKAY,   11'd8};
        vecs[5]  = '{1'b0, 32'h0000_1000, 4'b0000, 32'h0000_0000, CB_SLVERR, 11'd0};
        vecs[6]  = '{1'b1, 32'h8000_1FFC, 4'b1111, 32'hCAFE_F00D, CB_OKAY,   11'd2047};
        vecs[7]  = '{1'b0, 32'h8000_1FFC, 4'b0000, 32'hCAFE_F00D, CB_OKAY,   11'd2047};
        vecs[8]  = '{1'b0, 32'h8000_2000, 4'b0000, 32'h0000_0000, CB_SLVERR, 11'd0};
        vecs[9]  = '{1'b0, 32'h7FFF_FFFC, 4'b0000, 32'h0000_0000, CB_SLVERR, 11'd0};
        vecs[10] = '{1'b1, 32'h8000_0000, 4'b1111, 32'hA5A5_A5A5, CB_OKAY,   11'd0};
        vecs[11] = '{1'b1, 32'h8000_0003, 4'b0001, 32'h0000_00EE, CB_OKAY,   11'd0};
        vecs[12] = '{1'b1, 32'h8000_2000, 4'b1111, 32'h1234_5678, CB_SLVERR, 11'd0};
        vecs[13] = '{1'b1, 32'hFFFF_FFFC, 4'b1111, 32'h0000_0000, CB_SLVERR, 11'd0};
        vecs[14] = '{1'b0, 32'h8000_0000, 4'b0000, 32'hA5A5_A5EE, CB_OKAY,   11'd0};
        vecs[15] = '{1'b0, 32'h8000_0010, 4'b0000, 32'hDEAD_BEEF, CB_OKAY,   11'd4};
        vecs[16] = '{1'b0, 32'h8000_1FFC, 4'b0000, 32'hCAFE_F00D, CB_OKAY,   11'd2047};

        mosi = '0;

        // ---- reset state (a hit read request is presented to prove it is masked)
        mosi.rd_addr_valid = 1'b1;
        mosi.rd_addr       = 32'h8000_0010;
        #2;
        chk("rst_wr_addr_ready", 32'(miso.wr_addr_ready), 32'd1);
        chk("rst_rd_addr_ready", 32'(miso.rd_addr_ready), 32'd1);
        chk("rst_wr_data_ready", 32'(miso.wr_data_ready), 32'd0);
        chk("rst_wr_resp_valid", 32'(miso.wr_resp_valid), 32'd0);
        chk("rst_rd_valid", 32'(miso.rd_valid), 32'd0);
        chk("rst_sram_en", 32'(sram_en), 32'd0);
        chk("rst_sram_we", 32'(sram_we), 32'd0);
        $display("reset state checked");
        mosi.rd_addr_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();

        // ---- vector table
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].is_wr)
                do_write(vecs[i].addr, vecs[i].strb, vecs[i].data, vecs[i].resp, vecs[i].word);
            else
                do_read(vecs[i].addr, vecs[i].resp, vecs[i].data, vecs[i].word);
        end

        // ---- read back-pressure: 3 stalled cycles, next read accepted on rd_done
        do_write(32'h8000_0014, 4'b1111, 32'h5566_7788, CB_OKAY, 11'd5);
        mosi.rd_addr_valid = 1'b1;
        mosi.rd_addr       = 32'h8000_0014;
        mosi.rd_ready      = 1'b0;
        step();
        mosi.rd_addr       = 32'h8000_0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_rd_valid", 32'(miso.rd_valid), 32'd1);
            chk("bp_rd_data", miso.rd_data, 32'h5566_7788);
            chk("bp_rd_addr_ready", 32'(miso.rd_addr_ready), 32'd0);
            chk("bp_sram_en", 32'(sram_en), 32'd0);
            step();
        end
        mosi.rd_ready = 1'b1;
        #1;
        chk("bp_done_data", miso.rd_data, 32'h5566_7788);
        chk("bp_done_rd_addr_ready", 32'(miso.rd_addr_ready), 32'd1);
        chk("bp_done_sram_en", 32'(sram_en), 32'd1);
        chk("bp_done_sram_addr", 32'(sram_addr), 32'd4);
        step();
        mosi.rd_addr_valid = 1'b0;
        #1;
        chk("bp_next_rd_valid", 32'(miso.rd_valid), 32'd1);
        chk("bp_next_rd_data", miso.rd_data, 32'hDEAD_BEEF);
        step();
        chk("bp_idle", 32'(miso.rd_valid), 32'd0);
        $display("read back-pressure sequence done");

        // ---- back-to-back reads, one per cycle
        b2b_addr[0] = 32'h8000_0010; b2b_data[0] = 32'hDEAD_BEEF;
        b2b_addr[1] = 32'h8000_0014; b2b_data[1] = 32'h5566_7788;
        b2b_addr[2] = 32'h8000_0020; b2b_data[2] = 32'h11AA_3344;
        for (int i = 0; i < 3; i++) begin
            mosi.rd_addr_valid = 1'b1;
            mosi.rd_addr       = b2b_addr[i];
            #1;
            chk("b2b_rd_addr_ready", 32'(miso.rd_addr_ready), 32'd1);
            if (i > 0) chk("b2b_rd_data", miso.rd_data, b2b_data[i-1]);
            step();
        end
        mosi.rd_addr_valid = 1'b0;
        #1;
        chk("b2b_rd_last", miso.rd_data, b2b_data[2]);
        step();
        mosi.rd_ready = 1'b0;
        $display("back-to-back reads done");

        // ---- back-to-back writes: next address taken during current data beat
        mosi.wr_addr_valid = 1'b1;
        mosi.wr_addr       = 32'h8000_0030;
        step();
        mosi.wr_addr       = 32'h8000_0034;
        mosi.wr_data_valid = 1'b1;
        mosi.wr_data       = 32'h1357_9BDF;
        mosi.wr_strobe     = 4'b1111;
        mosi.wr_resp_ready = 1'b1;
        #1;
        chk("b2bw_wr_addr_ready", 32'(miso.wr_addr_ready), 32'd1);
        chk("b2bw_sram_addr0", 32'(sram_addr), 32'd12);
        step();
        mosi.wr_addr_valid = 1'b0;
        mosi.wr_data       = 32'h2468_ACE0;
        #1;
        chk("b2bw_wr_data_ready", 32'(miso.wr_data_ready), 32'd1);
        chk("b2bw_resp0", 32'(miso.wr_resp_valid), 32'd1);
        chk("b2bw_sram_addr1", 32'(sram_addr), 32'd13);
        step();
        mosi.wr_data_valid = 1'b0;
        chk("b2bw_resp1", 32'(miso.wr_resp_valid), 32'd1);
        step();
        mosi.wr_resp_ready = 1'b0;
        chk("b2bw_resp_idle", 32'(miso.wr_resp_valid), 32'd0);
        $display("back-to-back writes done");
        do_read(32'h8000_0030, CB_OKAY, 32'h1357_9BDF, 11'd12);
        do_read(32'h8000_0034, CB_OKAY, 32'h2468_ACE0, 11'd13);

        // ---- write/read collision: write wins, read follows and sees new data
        mosi.wr_addr_valid = 1'b1;
        mosi.wr_addr       = 32'h8000_0040;
        step();
        mosi.wr_addr_valid = 1'b0;
        mosi.wr_data_valid = 1'b1;
        mosi.wr_data       = 32'h0F0F_1234;
        mosi.wr_strobe     = 4'b1111;
        mosi.rd_addr_valid = 1'b1;
        mosi.rd_addr       = 32'h8000_0040;
        mosi.rd_ready      = 1'b1;
        #1;
        chk("col_rd_addr_ready", 32'(miso.rd_addr_ready), 32'd0);
        chk("col_sram_we", 32'(sram_we), 32'hF);
        step();
        mosi.wr_data_valid = 1'b0;
        mosi.wr_resp_ready = 1'b1;
        #1;
        chk("col_rd_accept", 32'(miso.rd_addr_ready), 32'd1);
        chk("col_rd_sram_en", 32'(sram_en), 32'd1);
        chk("col_rd_sram_we", 32'(sram_we), 32'd0);
        step();
        mosi.rd_addr_valid = 1'b0;
        mosi.wr_resp_ready = 1'b0;
        #1;
        chk("col_rd_valid", 32'(miso.rd_valid), 32'd1);
        chk("col_rd_data", miso.rd_data, 32'h0F0F_1234);
        step();
        mosi.rd_ready = 1'b0;
        $display("write/read collision done");

        // ---- reset with a response, a queued address and a read all pending
        mosi.wr_addr_valid = 1'b1;
        mosi.wr_addr       = 32'h8000_0050;
        step();
        mosi.wr_addr       = 32'h8000_0054;
        mosi.wr_data_valid = 1'b1;
        mosi.wr_data       = 32'h7777_7777;
        step();
        mosi.wr_addr_valid = 1'b0;
        mosi.wr_data_valid = 1'b0;
        mosi.rd_addr_valid = 1'b1;
        mosi.rd_addr       = 32'h8000_0010;
        #1;
        chk("mid_resp_valid", 32'(miso.wr_resp_valid), 32'd1);
        step();
        mosi.rd_addr_valid = 1'b0;
        #1;
        chk("mid_rd_valid", 32'(miso.rd_valid), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("async_resp_valid", 32'(miso.wr_resp_valid), 32'd0);
        chk("async_rd_valid", 32'(miso.rd_valid), 32'd0);
        chk("async_wr_data_ready", 32'(miso.wr_data_ready), 32'd0);
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_rst_resp_valid", 32'(miso.wr_resp_valid), 32'd0);
            chk("post_rst_rd_valid", 32'(miso.rd_valid), 32'd0);
            chk("post_rst_wr_data_ready", 32'(miso.wr_data_ready), 32'd0);
            step();
        end
        $display("reset mid-operation done");
        do_write(32'h8000_0058, 4'b1111, 32'h600D_CAFE, CB_OKAY, 11'd22);
        do_read(32'h8000_0058, CB_OKAY, 32'h600D_CAFE, 11'd22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
